// File: rtl/alu_sequencer_if.sv
// Request/result bundle for alu_sequencer. The master side issues operations
// and the slave side (the sequencer) returns status and results.
interface alu_sequencer_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [1:0]             op;
    logic [WIDTH-1:0]       operand_a;
    logic [WIDTH-1:0]       operand_b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     result;
    logic                   div_by_zero;

    modport master (
        output start, op, operand_a, operand_b,
        input  busy, done, result, div_by_zero
    );

    modport slave (
        input  start, op, operand_a, operand_b,
        output busy, done, result, div_by_zero
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle signed ALU: single-cycle add/sub, WIDTH-step shift-add multiply
// and restoring divide on magnitudes, with the sign applied at the end.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; operands latched as sign + magnitude
// S_ADDSUB | one cycle: full-width add or subtract, then done
// S_MUL    | WIDTH shift-add steps, multiplier consumed LSB-first
// S_DIV    | WIDTH restoring steps, quotient built MSB-first (or /0 exit)
// S_FIN    | apply sign to magnitude result, then done
module alu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic            i_clock,
    input  logic            i_reset,
    alu_sequencer_if.slave  io_bus
);
    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDSUB,
        S_MUL,
        S_DIV,
        S_FIN
    } state_t;

    state_t             r_state;
    logic               r_sub;
    logic               r_sign_a;
    logic               r_sign_b;
    logic [WIDTH:0]     r_mag_a;
    logic [WIDTH:0]     r_mag_b;
    logic [CW-1:0]      r_cnt;
    logic [RW-1:0]      r_acc;
    logic [WIDTH:0]     r_rem;
    logic               r_busy;
    logic               r_done;
    logic [RW-1:0]      r_result;
    logic               r_dbz;

    state_t             w_state_nxt;
    logic               w_sub_nxt;
    logic               w_sign_a_nxt;
    logic               w_sign_b_nxt;
    logic [WIDTH:0]     w_mag_a_nxt;
    logic [WIDTH:0]     w_mag_b_nxt;
    logic [CW-1:0]      w_cnt_nxt;
    logic [RW-1:0]      w_acc_nxt;
    logic [WIDTH:0]     w_rem_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic [RW-1:0]      w_result_nxt;
    logic               w_dbz_nxt;

    logic [WIDTH:0]     w_a_ext;
    logic [WIDTH:0]     w_b_ext;
    logic [WIDTH:0]     w_a_mag_in;
    logic [WIDTH:0]     w_b_mag_in;
    logic [RW-1:0]      w_mag_a_ext;
    logic [RW-1:0]      w_mag_b_ext;
    logic [RW-1:0]      w_val_a;
    logic [RW-1:0]      w_val_b;
    logic [RW-1:0]      w_sum;
    logic [RW-1:0]      w_addend;
    logic [WIDTH+1:0]   w_shift_rem;
    logic [WIDTH+1:0]   w_trial;
    logic               w_q_bit;
    logic               w_last;
    logic               w_neg;

    // Magnitudes carry one extra bit so the most negative operand stays exact.
    assign w_a_ext     = {io_bus.operand_a[WIDTH-1], io_bus.operand_a};
    assign w_b_ext     = {io_bus.operand_b[WIDTH-1], io_bus.operand_b};
    assign w_a_mag_in  = w_a_ext[WIDTH] ? -w_a_ext : w_a_ext;
    assign w_b_mag_in  = w_b_ext[WIDTH] ? -w_b_ext : w_b_ext;

    assign w_mag_a_ext = {{(RW-WIDTH-1){1'b0}}, r_mag_a};
    assign w_mag_b_ext = {{(RW-WIDTH-1){1'b0}}, r_mag_b};
    assign w_val_a     = r_sign_a ? -w_mag_a_ext : w_mag_a_ext;
    assign w_val_b     = r_sign_b ? -w_mag_b_ext : w_mag_b_ext;
    assign w_sum       = r_sub ? (w_val_a - w_val_b) : (w_val_a + w_val_b);

    assign w_addend    = r_mag_b[r_cnt] ? (w_mag_a_ext << r_cnt) : '0;

    // Dividend sits in r_acc[WIDTH-1:0] and shifts out MSB-first while quotient bits shift in.
    assign w_shift_rem = {r_rem, r_acc[WIDTH-1]};
    assign w_trial     = w_shift_rem - {1'b0, r_mag_b};
    assign w_q_bit     = ~w_trial[WIDTH+1];

    assign w_last      = (r_cnt == CW'(WIDTH - 1));
    assign w_neg       = r_sign_a ^ r_sign_b;

    always_comb begin
        w_state_nxt  = r_state;
        w_sub_nxt    = r_sub;
        w_sign_a_nxt = r_sign_a;
        w_sign_b_nxt = r_sign_b;
        w_mag_a_nxt  = r_mag_a;
        w_mag_b_nxt  = r_mag_b;
        w_cnt_nxt    = r_cnt;
        w_acc_nxt    = r_acc;
        w_rem_nxt    = r_rem;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_result_nxt = r_result;
        w_dbz_nxt    = r_dbz;

        case (r_state)
            S_IDLE: begin
                if (io_bus.start) begin
                    w_sub_nxt    = io_bus.op[0];
                    w_sign_a_nxt = io_bus.operand_a[WIDTH-1];
                    w_sign_b_nxt = io_bus.operand_b[WIDTH-1];
                    w_mag_a_nxt  = w_a_mag_in;
                    w_mag_b_nxt  = w_b_mag_in;
                    w_cnt_nxt    = '0;
                    w_rem_nxt    = '0;
                    w_busy_nxt   = 1'b1;
                    w_acc_nxt    = (io_bus.op == 2'b11) ?
                                   {{(RW-WIDTH){1'b0}}, w_a_mag_in[WIDTH-1:0]} : '0;
                    case (io_bus.op)
                        2'b10:   w_state_nxt = S_MUL;
                        2'b11:   w_state_nxt = S_DIV;
                        default: w_state_nxt = S_ADDSUB;
                    endcase
                end
            end

            S_ADDSUB: begin
                w_result_nxt = w_sum;
                w_dbz_nxt    = 1'b0;
                w_done_nxt   = 1'b1;
                w_busy_nxt   = 1'b0;
                w_state_nxt  = S_IDLE;
            end

            S_MUL: begin
                w_acc_nxt = r_acc + w_addend;
                w_cnt_nxt = r_cnt + CW'(1);
                if (w_last) begin
                    w_state_nxt = S_FIN;
                end
            end

            S_DIV: begin
                if (r_mag_b == '0) begin
                    w_result_nxt = '0;
                    w_dbz_nxt    = 1'b1;
                    w_done_nxt   = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_rem_nxt = w_q_bit ? w_trial[WIDTH:0] : w_shift_rem[WIDTH:0];
                    w_acc_nxt = {r_acc[RW-1:WIDTH], r_acc[WIDTH-2:0], w_q_bit};
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (w_last) begin
                        w_state_nxt = S_FIN;
                    end
                end
            end

            S_FIN: begin
                // Negating a zero magnitude yields zero, so no negative zero can appear.
                w_result_nxt = w_neg ? -r_acc : r_acc;
                w_dbz_nxt    = 1'b0;
                w_done_nxt   = 1'b1;
                w_busy_nxt   = 1'b0;
                w_state_nxt  = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_sub    <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_dbz    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sub    <= w_sub_nxt;
            r_sign_a <= w_sign_a_nxt;
            r_sign_b <= w_sign_b_nxt;
            r_mag_a  <= w_mag_a_nxt;
            r_mag_b  <= w_mag_b_nxt;
            r_cnt    <= w_cnt_nxt;
            r_acc    <= w_acc_nxt;
            r_rem    <= w_rem_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_result <= w_result_nxt;
            r_dbz    <= w_dbz_nxt;
        end
    end

    assign io_bus.busy        = r_busy;
    assign io_bus.done        = r_done;
    assign io_bus.result      = r_result;
    assign io_bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: hand-computed results, latency and busy
// width per operation, divide-by-zero, reset abort and ignored start.
module tb_alu_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_sequencer_if #(.WIDTH(8)) bus ();
    alu_sequencer #(.WIDTH(8)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .io_bus  (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [15:0] res;
    logic        dbz;
    int          lat;
    int          bcnt;

    // Called just after a falling edge; returns at the falling edge where done is seen.
    // lat = edges after the accepting edge until done; bcnt = cycles busy was high.
    task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0; bcnt = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
        res = bus.result;
        dbz = bus.div_by_zero;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.op = 2'b00; bus.operand_a = '0; bus.operand_b = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.result !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h want 0000", bus.result); end
        checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", bus.div_by_zero); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add();
        do_op(2'b00, 8'd9, 8'd7);
        checks++; if (res !== 16'd16) begin errors++; $display("FAIL add_result: got %h want 0010", res); end
        checks++; if (lat != 1) begin errors++; $display("FAIL add_latency: got %0d want 1", lat); end
        checks++; if (bcnt != 1) begin errors++; $display("FAIL add_busy_cycles: got %0d want 1", bcnt); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL add_busy_at_done: got %b want 0", bus.busy); end
        checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL add_dbz: got %b want 0", dbz); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL add_done_pulse: got %b want 0", bus.done); end
        checks++; if (bus.result !== 16'd16) begin errors++; $display("FAIL add_result_hold: got %h want 0010", bus.result); end
    endtask

    task automatic test_sub();
        do_op(2'b01, 8'hF7, 8'd7);
        checks++; if (res !== 16'hFFF0) begin errors++; $display("FAIL sub_neg_result: got %h want fff0", res); end
        checks++; if (lat != 1) begin errors++; $display("FAIL sub_latency: got %0d want 1", lat); end
        @(negedge clk);
        do_op(2'b01, 8'd9, 8'hF9);
        checks++; if (res !== 16'd16) begin errors++; $display("FAIL sub_pos_result: got %h want 0010", res); end
        @(negedge clk);
    endtask

    task automatic test_mul();
        do_op(2'b10, 8'd9, 8'hF9);
        checks++; if (res !== 16'hFFC1) begin errors++; $display("FAIL mul_result: got %h want ffc1", res); end
        checks++; if (lat != 9) begin errors++; $display("FAIL mul_latency: got %0d want 9", lat); end
        checks++; if (bcnt != 9) begin errors++; $display("FAIL mul_busy_cycles: got %0d want 9", bcnt); end
        checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL mul_dbz: got %b want 0", dbz); end
        @(negedge clk);
        do_op(2'b10, 8'h80, 8'h80);
        checks++; if (res !== 16'h4000) begin errors++; $display("FAIL mul_minmin: got %h want 4000", res); end
        @(negedge clk);
        do_op(2'b10, 8'd0, 8'hFB);
        checks++; if (res !== 16'h0000) begin errors++; $display("FAIL mul_zero_sign: got %h want 0000", res); end
        @(negedge clk);
    endtask

    task automatic test_div();
        do_op(2'b11, 8'hF7, 8'd7);
        checks++; if (res !== 16'hFFFF) begin errors++; $display("FAIL div_neg9_7: got %h want ffff", res); end
        checks++; if (lat != 9) begin errors++; $display("FAIL div_latency: got %0d want 9", lat); end
        checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL div_dbz_a: got %b want 0", dbz); end
        @(negedge clk);
        do_op(2'b11, 8'd9, 8'd7);
        checks++; if (res !== 16'h0001) begin errors++; $display("FAIL div_9_7: got %h want 0001", res); end
        checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL div_dbz_b: got %b want 0", dbz); end
        @(negedge clk);
        do_op(2'b11, 8'h80, 8'hFF);
        checks++; if (res !== 16'h0080) begin errors++; $display("FAIL div_min_neg1: got %h want 0080", res); end
        checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL div_dbz_c: got %b want 0", dbz); end
        @(negedge clk);
        do_op(2'b11, 8'd100, 8'hF9);
        checks++; if (res !== 16'hFFF2) begin errors++; $display("FAIL div_100_neg7: got %h want fff2", res); end
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        do_op(2'b11, 8'd5, 8'd0);
        checks++; if (res !== 16'h0000) begin errors++; $display("FAIL dz_result: got %h want 0000", res); end
        checks++; if (dbz !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b want 1", dbz); end
        checks++; if (lat != 1) begin errors++; $display("FAIL dz_latency: got %0d want 1", lat); end
        @(negedge clk);
        checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag_hold: got %b want 1", bus.div_by_zero); end
        do_op(2'b00, 8'd1, 8'd1);
        checks++; if (res !== 16'h0002) begin errors++; $display("FAIL dz_next_add: got %h want 0002", res); end
        checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL dz_next_flag: got %b want 0", dbz); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        do_op(2'b00, 8'd2, 8'd3);
        // still in the done cycle: a new start must be accepted
        bus.start = 1'b1; bus.op = 2'b01; bus.operand_a = 8'd10; bus.operand_b = 8'd4;
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", bus.busy); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", bus.done); end
        checks++; if (bus.result !== 16'h0006) begin errors++; $display("FAIL b2b_result: got %h want 0006", bus.result); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int seen_done;
        seen_done = 0;
        bus.start = 1'b1; bus.op = 2'b10; bus.operand_a = 8'd9; bus.operand_b = 8'hF9;
        @(negedge clk);                 // after accepting edge N
        bus.start = 1'b0;
        @(negedge clk);                 // after N+1
        if (bus.done === 1'b1) seen_done++;
        @(negedge clk);                 // after N+2; start sampled at N+3 must be ignored
        if (bus.done === 1'b1) seen_done++;
        bus.start = 1'b1; bus.op = 2'b00; bus.operand_a = 8'd1; bus.operand_b = 8'd1;
        @(negedge clk);                 // after N+3
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ign_start_busy: got %b want 1", bus.busy); end
        if (bus.done === 1'b1) seen_done++;
        @(negedge clk);                 // after N+4; a re-latched add would finish here
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL ign_start_done: got %b want 0", bus.done); end
        rst = 1'b1;                     // reset sampled at N+5
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        checks++; if (bus.result !== 16'h0000) begin errors++; $display("FAIL abort_result: got %h want 0000", bus.result); end
        if (bus.done === 1'b1) seen_done++;
        repeat (8) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen_done++;
        end
        checks++; if (seen_done != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", seen_done); end
        do_op(2'b10, 8'd3, 8'd3);
        checks++; if (res !== 16'h0009) begin errors++; $display("FAIL after_abort_mul: got %h want 0009", res); end
        checks++; if (lat != 9) begin errors++; $display("FAIL after_abort_latency: got %0d want 9", lat); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter: WIDTH, default 8, operand width in bits (two's complement); the result is 2*WIDTH bits.
REQ-003 Port: clock  input  1  rising-edge clock for all state.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  request to begin one operation; sampled only in IDLE.
REQ-006 Port: op  input  2  operation: 00 add, 01 sub, 10 mul, 11 div.
REQ-007 Port: operand_a  input  WIDTH  signed left operand; sampled with start.
REQ-008 Port: operand_b  input  WIDTH  signed right operand; sampled with start.
REQ-009 Port: busy  output  1  high while an accepted operation is in progress.
REQ-010 Port: done  output  1  one-cycle pulse; result and div_by_zero are valid when it is high.
REQ-011 Port: result  output  2*WIDTH  signed result; holds its value until the next done.
REQ-012 Port: div_by_zero  output  1  set with done when op=div and operand_b=0; holds until the next done.

Function
REQ-013 FSM states SHALL be IDLE, ADDSUB, MUL, DIV and FIN.
REQ-014 IDLE with start=1 at edge N:
- latch op, operand signs and magnitudes (|x| in WIDTH+1 bits, so |-128|=128);
- clear the iteration counter;
- set busy=1;
- go to ADDSUB for op 00/01, MUL for op 10, DIV for op 11.
REQ-015 start while busy=1 SHALL be ignored; the operands are not re-latched.
REQ-016 ADDSUB at edge N+1:
- result = sign-extended operand_a +/- operand_b at full 2*WIDTH width (no overflow possible);
- done=1, busy=0, div_by_zero=0; go to IDLE.
REQ-017 MUL:
- edges N+1..N+WIDTH: one shift-add step on magnitudes per edge (LSB-first multiplier);
- then go to FIN.
REQ-018 DIV with latched operand_b != 0:
- edges N+1..N+WIDTH: one restoring-division step per edge on magnitudes (quotient MSB-first);
- then go to FIN.
REQ-019 DIV with operand_b == 0, at edge N+1:
- result=0, div_by_zero=1, done=1, busy=0; go to IDLE;
- no iterations are performed.
REQ-020 FIN at edge N+WIDTH+1:
- result = magnitude result, negated when sign_a XOR sign_b;
- done=1, busy=0, div_by_zero=0; go to IDLE.
REQ-021 Division SHALL truncate toward zero; the remainder is discarded.
REQ-022 Latency SHALL be fixed, independent of operand values:
- done high in the cycle after edge N+1 for add, sub and divide-by-zero;
- done high in the cycle after edge N+WIDTH+1 for mul and div.
REQ-023 done SHALL be deasserted at the next edge.
REQ-024 A start asserted during the done cycle SHALL be accepted, because the FSM is in IDLE then.
REQ-025 Zero results SHALL never be negative zero, for example 0 * -5 = 0.

Reset
REQ-026 At any edge with reset=1, the block SHALL:
- go to IDLE;
- set busy=0, done=0, result=0, div_by_zero=0;
- clear the counter and all latched operands.
REQ-027 reset during ADDSUB, MUL, DIV or FIN SHALL abort the operation with no done pulse.
REQ-028 reset SHALL take priority over start in the same cycle.

Verification
REQ-029 Scenario: add.
- Stimulus: op=00, a=9, b=7.
- Required: result=16, done in the cycle after N+1, busy high for exactly 1 cycle.
REQ-030 Scenario: sub.
- Stimulus: op=01, a=-9, b=7.
- Required: result=-16 (0xFFF0).
- Then op=01, a=9, b=-7: result=16.
REQ-031 Scenario: mul.
- Stimulus: op=10, a=9, b=-7.
- Required: result=-63, done in the cycle after N+9, busy high for 9 cycles.
- Then a=-128, b=-128: result=16384.
REQ-032 Scenario: div.
- Stimulus: op=11, a=-9, b=7 -> result=-1.
- a=9, b=7 -> result=1.
- a=-128, b=-1 -> result=128.
- div_by_zero=0 in each case.
REQ-033 Scenario: divide by zero.
- Stimulus: op=11, a=5, b=0.
- Required: result=0, div_by_zero=1, done in the cycle after N+1.
- The next add, 1+1, gives result=2 and div_by_zero=0.
REQ-034 Scenario: reset mid-op and ignored start.
- Assert start during mul iteration 3: it is ignored.
- Assert reset at iteration 5: busy=0, result=0, no done.
- A following 3*3 gives result=9.
